// File: rtl/palette_pkg.sv
// Shared definitions for the CPU-side palette writer: default widths,
// palette size and the commit state encoding.
package palette_pkg;

  localparam int PAL_DATA_W  = 8;
  localparam int PAL_IDX_W   = 4;
  localparam int PAL_ENTRIES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } pal_state_e;

endpackage

// File: rtl/palette_fifo.sv
// Small synchronous FIFO for queued palette writes. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module palette_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk24,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] pending,
  output logic          full
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          full_r;
  logic          do_push_s;
  logic          do_pop_s;

  // accept/remove decisions and next occupancy
  always_comb begin
    do_pop_s  = pop && (cnt_r != {CW{1'b0}});
    do_push_s = push && (!full_r || do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      cnt_r  <= cnt_nxt_s;
      full_r <= (cnt_nxt_s == CW'(DEPTH));
    end
  end

  // entry storage
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout    = mem_r[rd_ptr_r];
  assign pending = cnt_r;
  assign full    = full_r;

endmodule

// File: rtl/palette_writer.sv
// Queues CPU palette writes and commits them to the palette RAM only in
// cycles the video scan leaves free; keeps a shadow copy for readback.
module palette_writer
  import palette_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = PAL_DATA_W,
  parameter int IDX_W  = PAL_IDX_W
) (
  input  logic                    clk24,
  input  logic                    reset_n,
  input  logic                    wr_stb,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic                    vid_slot_next,
  input  logic                    retrace,
  input  logic                    retrace_only,
  output logic [IDX_W-1:0]        pal_addr,
  output logic [DATA_W-1:0]       pal_data,
  output logic                    pal_we,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    overflow,
  input  logic                    overflow_clr,
  input  logic [IDX_W-1:0]        rb_idx,
  output logic [DATA_W-1:0]       rb_data
);

  localparam int W = IDX_W + DATA_W;

  pal_state_e        state_r;
  pal_state_e        state_nxt_s;
  logic [W-1:0]      head_s;
  logic              avail_r;
  logic              go_s;
  logic              pop_s;
  logic              commit_s;
  logic              drop_s;
  logic              overflow_r;
  logic              pal_we_r;
  logic [IDX_W-1:0]  pal_addr_r;
  logic [DATA_W-1:0] pal_data_r;
  logic [DATA_W-1:0] shadow_r [PAL_ENTRIES];

  palette_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk24   (clk24),
    .reset_n (reset_n),
    .push    (wr_stb),
    .pop     (pop_s),
    .din     ({wr_idx, wr_data}),
    .dout    (head_s),
    .pending (pending),
    .full    (full)
  );

  // a queued write becomes visible to the commit logic one cycle after it lands
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) avail_r <= 1'b0;
    else          avail_r <= (pending != '0);
  end

  // commit eligibility: look-ahead keeps pal_we out of video read cycles
  always_comb begin
    go_s = 1'b0;
    if (avail_r && !vid_slot_next && (!retrace_only || retrace)) go_s = 1'b1;
    else                                                          go_s = 1'b0;
  end

  // state register
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (go_s) state_nxt_s = WRITE; else state_nxt_s = IDLE;
      WRITE:   state_nxt_s = HOLD;
      HOLD:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // per-state controls
  always_comb begin
    pop_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE:    pop_s    = go_s;
      WRITE:   commit_s = 1'b1;
      HOLD:    commit_s = 1'b0;
      default: commit_s = 1'b0;
    endcase
    drop_s = wr_stb && full && !pop_s;
  end

  // RAM write port: address/data stay put through WRITE and HOLD
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      pal_we_r   <= 1'b0;
      pal_addr_r <= {IDX_W{1'b0}};
      pal_data_r <= {DATA_W{1'b0}};
    end else begin
      pal_we_r <= pop_s;
      if (pop_s) begin
        pal_addr_r <= head_s[W-1:DATA_W];
        pal_data_r <= head_s[DATA_W-1:0];
      end
    end
  end

  // sticky drop flag, a new drop beats a clear
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n)          overflow_r <= 1'b0;
    else if (drop_s)       overflow_r <= 1'b1;
    else if (overflow_clr) overflow_r <= 1'b0;
    else                   overflow_r <= overflow_r;
  end

  // shadow follows committed writes only
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) shadow_r[i] <= {DATA_W{1'b0}};
    end else if (commit_s) begin
      shadow_r[pal_addr_r] <= pal_data_r;
    end
  end

  assign pal_we   = pal_we_r;
  assign pal_addr = pal_addr_r;
  assign pal_data = pal_data_r;
  assign overflow = overflow_r;
  assign rb_data  = shadow_r[rb_idx];

endmodule

// File: tb/tb_palette_writer.sv
// Scoreboard bench for palette_writer: stimulus queues expected commits,
// a negedge monitor pops and compares every pal_we cycle.
module tb_palette_writer;

  logic       clk24 = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [3:0] wr_idx = 4'h0;
  logic       vid_slot_next = 1'b0;
  logic       retrace = 1'b0;
  logic       retrace_only = 1'b0;
  logic [3:0] pal_addr;
  logic [7:0] pal_data;
  logic       pal_we;
  logic       full;
  logic [2:0] pending;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic [3:0] rb_idx = 4'h0;
  logic [7:0] rb_data;

  palette_writer dut (
    .clk24(clk24), .reset_n(reset_n), .wr_stb(wr_stb), .wr_data(wr_data),
    .wr_idx(wr_idx), .vid_slot_next(vid_slot_next), .retrace(retrace),
    .retrace_only(retrace_only), .pal_addr(pal_addr), .pal_data(pal_data),
    .pal_we(pal_we), .full(full), .pending(pending), .overflow(overflow),
    .overflow_clr(overflow_clr), .rb_idx(rb_idx), .rb_data(rb_data)
  );

  always #5 clk24 = ~clk24;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_commit = 0;
  int          cyc = 0;
  int          last_we = -100;
  logic        vid_at_edge = 1'b0;
  bit          toggle_en = 1'b0;
  logic [11:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    else n_pass++;
  endtask

  // ce12-style look-ahead pattern generator
  always @(posedge clk24) begin
    #1;
    if (toggle_en) vid_slot_next = ~vid_slot_next;
    else           vid_slot_next = 1'b0;
  end

  always @(posedge clk24) begin
    cyc++;
    vid_at_edge = vid_slot_next;
  end

  // monitor: every RAM write is checked against the scoreboard
  always @(negedge clk24) begin
    if (pal_we === 1'b1) begin
      n_commit++;
      chk("vid_free_before_we", {31'd0, vid_at_edge}, 32'd0);
      n_chk++;
      if (cyc - last_we < 3) $display("FAIL commit_gap: actual=%0d cycles expected>=3", cyc - last_we);
      else n_pass++;
      last_we = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_commit: actual addr=%0h data=%0h expected none", pal_addr, pal_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("commit_addr", {28'd0, pal_addr}, {28'd0, e[11:8]});
        chk("commit_data", {24'd0, pal_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic wr(input logic [3:0] idx, input logic [7:0] d, input bit accept);
    wr_stb = 1'b1; wr_idx = idx; wr_data = d;
    if (accept) exp_q.push_back({idx, d});
    @(posedge clk24); #1;
    wr_stb = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && pending == 3'd0) break;
      @(posedge clk24); #1;
    end
    chk(nm, exp_q.size(), 32'd0);
    repeat (3) @(posedge clk24);
    #1;
  endtask

  initial begin
    int c0;
    int bad;
    bit found;
    repeat (3) @(posedge clk24);
    #1 reset_n = 1'b1;
    chk("rst_pal_we", {31'd0, pal_we}, 32'd0);
    chk("rst_pal_addr", {28'd0, pal_addr}, 32'd0);
    chk("rst_pal_data", {24'd0, pal_data}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rb_data", {24'd0, rb_data}, 32'd0);

    // single write latency: pal_we two edges after the sampling edge
    wr(4'd5, 8'hA4, 1'b1);
    chk("lat_pending", {29'd0, pending}, 32'd1);
    @(posedge clk24); @(negedge clk24);
    chk("lat_we_early", {31'd0, pal_we}, 32'd0);
    @(posedge clk24); @(negedge clk24);
    chk("lat_we_on_time", {31'd0, pal_we}, 32'd1);
    drain("drain_single");
    rb_idx = 4'd5; #1;
    chk("rb_5", {24'd0, rb_data}, 32'h0000_00A4);
    chk("pending_empty", {29'd0, pending}, 32'd0);

    // commits under the alternating video pattern
    toggle_en = 1'b1;
    c0 = n_commit;
    wr(4'd1, 8'h10, 1'b1);
    wr(4'd2, 8'h20, 1'b1);
    wr(4'd7, 8'h70, 1'b1);
    drain("drain_ce12");
    toggle_en = 1'b0;
    chk("ce12_commits", n_commit - c0, 32'd3);
    rb_idx = 4'd7; #1;
    chk("rb_7", {24'd0, rb_data}, 32'h0000_0070);

    // retrace-only hold, fill, overflow, drain
    retrace_only = 1'b1; retrace = 1'b0;
    c0 = n_commit;
    wr(4'd0, 8'h01, 1'b1);
    wr(4'd1, 8'h02, 1'b1);
    wr(4'd2, 8'h03, 1'b1);
    wr(4'd3, 8'h04, 1'b1);
    repeat (5) @(posedge clk24);
    #1;
    chk("hold_full", {31'd0, full}, 32'd1);
    chk("hold_pending", {29'd0, pending}, 32'd4);
    chk("hold_no_commit", n_commit - c0, 32'd0);
    chk("hold_no_overflow", {31'd0, overflow}, 32'd0);
    wr(4'd9, 8'hEE, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_pending", {29'd0, pending}, 32'd4);
    overflow_clr = 1'b1;
    wr(4'd9, 8'hEF, 1'b0);
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    @(posedge clk24); #1;
    overflow_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    retrace = 1'b1;
    drain("drain_retrace");
    chk("retrace_commits", n_commit - c0, 32'd4);
    rb_idx = 4'd3; #1;
    chk("rb_3_after_drain", {24'd0, rb_data}, 32'h0000_0004);

    // full FIFO: pop and push on the same edge
    retrace = 1'b0;
    wr(4'd8, 8'h81, 1'b1);
    wr(4'd9, 8'h91, 1'b1);
    wr(4'd10, 8'hA1, 1'b1);
    wr(4'd11, 8'hB1, 1'b1);
    @(posedge clk24); #1;
    retrace = 1'b1;
    wr(4'd12, 8'hC1, 1'b1);
    chk("pp_pending", {29'd0, pending}, 32'd4);
    chk("pp_overflow", {31'd0, overflow}, 32'd0);
    chk("pp_we", {31'd0, pal_we}, 32'd1);
    drain("drain_pushpop");
    rb_idx = 4'd12; #1;
    chk("rb_12", {24'd0, rb_data}, 32'h0000_00C1);
    retrace_only = 1'b0; retrace = 1'b0;

    // same index twice: last write wins
    wr(4'd3, 8'h11, 1'b1);
    wr(4'd3, 8'h22, 1'b1);
    drain("drain_same_idx");
    rb_idx = 4'd3; #1;
    chk("rb_3_last_wins", {24'd0, rb_data}, 32'h0000_0022);

    // reset during the WRITE cycle
    wr(4'd14, 8'h5A, 1'b1);
    wr(4'd15, 8'h6B, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk24); #2;
      if (pal_we === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_write", {31'd0, found}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_we_drop", {31'd0, pal_we}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk24);
    #1 reset_n = 1'b1;
    chk("rst_pending_clear", {29'd0, pending}, 32'd0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rb_idx = 4'(i); #1;
      if (rb_data !== 8'h00) bad++;
    end
    chk("rst_shadow_zero", bad, 32'd0);
    c0 = n_commit;
    repeat (10) @(posedge clk24);
    #1;
    chk("rst_no_stale", n_commit - c0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
